wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage RISC-V pipeline. It latches the instruction leaving MEM and drives the register-file/CSR write bus consumed by decode. Decode commits at most one write per cycle and gives a GPR write priority over a CSR write, so this block serialises instructions that write both a GPR and a CSR (CSRR/CSRW pairs), back-pressures MEM while it does so, counts retired instructions and detects the halt CSR write.

## Interface
- DBITS, 32, data/PC width
- REGNOBITS, 5, GPR index width
- CSRNOBITS, 4, CSR index width (16 CSRs)
- HALT_CSR, 4'hF, CSR index whose nonzero write halts the core
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clk, reset==0 resets the block
- mem_valid  in  1  MEM presents an instruction this cycle
- mem_pc  in  DBITS  PC of that instruction
- mem_wr_reg  in  1  instruction writes GPR
- mem_wregno  in  REGNOBITS  destination GPR
- mem_regval  in  DBITS  GPR write data
- mem_wr_csr  in  1  instruction writes CSR
- mem_wcsrno  in  CSRNOBITS  destination CSR
- mem_csrval  in  DBITS  CSR write data
- wb_stall  out  1  MEM must hold its current instruction; combinational
- from_WB_to_DE  out  1+REGNOBITS+DBITS+CSRNOBITS+1  packed {wr_reg_WB, wregno_WB, regval_WB, wcsrno_WB, wr_csr_WB}; combinational from WB latch and state
- retired_count  out  DBITS  instructions retired since reset
- halted  out  1  halt CSR write has retired

## Operation
- WB latch: valid, pc, wr_reg, wregno, regval, wr_csr, wcsrno, csrval. Loaded with mem_* on posedge when wb_stall==0 and state!=HALT; valid<=mem_valid.
- wr_reg_eff = valid & wr_reg & (wregno!=0); writes to x0 never reach the bus.
- States: RUN, CSR2, HALT. Reset -> RUN.
- RUN, valid, wr_reg_eff, wr_csr: bus drives GPR write only (wr_reg_WB=1, wr_csr_WB=0, regval_WB=regval); wb_stall=1; next state CSR2.
- CSR2: bus drives CSR write (wr_reg_WB=0, wr_csr_WB=1, regval_WB=csrval, wcsrno_WB=wcsrno); wb_stall=0; instruction retires; next RUN (or HALT, below).
- RUN, single write or no write: bus drives that write (regval_WB=regval for GPR, csrval for CSR); wb_stall=0; instruction retires this cycle.
- Retire: retired_count +1 (mod 2^DBITS) on the posedge ending the retiring cycle; invalid latch retires nothing.
- Halt: retiring CSR write with wcsrno==HALT_CSR and csrval!=0 -> next state HALT, halted<=1. The halt write itself reaches the bus and is counted.
- HALT: latch frozen, bus all-zero, wb_stall=1, counter frozen; only reset exits.
- Bus fields with their enable low drive 0.

## Timing
- Reset values: latch valid=0, state RUN, retired_count=0, halted=0, from_WB_to_DE=0, wb_stall=0.
- Latency: instruction on mem_* at edge N is on the write bus during cycle N..N+1; decode writes on the following negedge. Dual-write instructions occupy two cycles.
- wb_stall is a pure function of state and latch; it never depends on mem_* inputs (no combinational loop with MEM).
- Back-to-back single-write instructions: one per cycle, no bubbles.
- Reset low mid-CSR2 or in HALT: pending CSR write is dropped, all state returns to reset values on that edge.
- mem_valid=0 with wr bits set: ignored (nothing written, nothing counted).
- Counter wrap: 0xFFFFFFFF +1 -> 0x00000000, no flag.

## Test plan
- Reset: hold reset=0 three cycles with mem_valid=1 -> bus 0, wb_stall=0, retired_count=0, halted=0; release -> first instruction captured next edge.
- Stream: ADDI x5=0x11, x6=0x22, x7=0x33 on consecutive cycles -> bus shows {1,5,0x11,0,0},{1,6,0x22,0,0},{1,7,0x33,0,0} on consecutive cycles, wb_stall never 1, retired_count=3.
- x0 suppression: wr_reg=1, wregno=0, regval=0xDEAD -> wr_reg_WB=0, bus 0, retired_count +1.
- Dual write: wregno=3 regval=0x5, wcsrno=2 csrval=0xA5 -> cycle 1 GPR write and wb_stall=1 with next MEM instruction held; cycle 2 CSR write {0,0,0xA5,2,1}, wb_stall=0; held instruction appears cycle 3; count +1 only.
- Halt: CSR write wcsrno=0xF csrval=1 -> write on bus, halted=1 next cycle, wb_stall=1, later mem_valid inputs ignored, count frozen; csrval=0 to 0xF does not halt.
- Reset mid-CSR2 and counter preset near 0xFFFFFFFF (force) -> CSR write dropped, state RUN; wrap to 0 verified.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: latches the MEM result and drives the decode write bus.
// Splits GPR+CSR dual writes over two cycles, counts retirements, detects halt.
module wb_stage #(
  parameter int DBITS = 32,
  parameter int REGNOBITS = 5,
  parameter int CSRNOBITS = 4,
  parameter logic [CSRNOBITS-1:0] HALT_CSR = 'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic [DBITS-1:0]     mem_pc,
  input  logic                 mem_wr_reg,
  input  logic [REGNOBITS-1:0] mem_wregno,
  input  logic [DBITS-1:0]     mem_regval,
  input  logic                 mem_wr_csr,
  input  logic [CSRNOBITS-1:0] mem_wcsrno,
  input  logic [DBITS-1:0]     mem_csrval,
  output logic                 wb_stall,
  output logic [REGNOBITS+DBITS+CSRNOBITS+1:0] from_WB_to_DE,
  output logic [DBITS-1:0]     retired_count,
  output logic                 halted
);

  typedef enum logic [1:0] {RUN, CSR2, HALT} state_t;

  state_t state, state_nxt;

  logic                 v_q;
  logic [DBITS-1:0]     pc_q;
  logic                 wr_reg_q;
  logic [REGNOBITS-1:0] wregno_q;
  logic [DBITS-1:0]     regval_q;
  logic                 wr_csr_q;
  logic [CSRNOBITS-1:0] wcsrno_q;
  logic [DBITS-1:0]     csrval_q;

  logic wr_reg_eff;
  logic wr_csr_eff;
  logic halt_wr;
  logic retire;

  logic                 bus_wr_reg;
  logic [REGNOBITS-1:0] bus_wregno;
  logic [DBITS-1:0]     bus_val;
  logic [CSRNOBITS-1:0] bus_wcsrno;
  logic                 bus_wr_csr;

  // PC travels with the instruction for debug visibility only.
  logic unused_pc;
  assign unused_pc = ^pc_q;

  assign wr_reg_eff = v_q & wr_reg_q & (wregno_q != '0);
  assign wr_csr_eff = v_q & wr_csr_q;
  assign halt_wr = (wcsrno_q == HALT_CSR) && (csrval_q != '0);

  assign from_WB_to_DE = {bus_wr_reg, bus_wregno, bus_val,
                          bus_wcsrno, bus_wr_csr};

  // Write-bus select, stall, retire and next state.
  always_comb begin
    state_nxt  = state;
    wb_stall   = 1'b0;
    retire     = 1'b0;
    bus_wr_reg = 1'b0;
    bus_wregno = '0;
    bus_val    = '0;
    bus_wcsrno = '0;
    bus_wr_csr = 1'b0;
    case (state)
      RUN: begin
        if (wr_reg_eff && wr_csr_eff) begin
          bus_wr_reg = 1'b1;
          bus_wregno = wregno_q;
          bus_val    = regval_q;
          wb_stall   = 1'b1;
          state_nxt  = CSR2;
        end else begin
          retire = v_q;
          if (wr_reg_eff) begin
            bus_wr_reg = 1'b1;
            bus_wregno = wregno_q;
            bus_val    = regval_q;
          end else if (wr_csr_eff) begin
            bus_wr_csr = 1'b1;
            bus_wcsrno = wcsrno_q;
            bus_val    = csrval_q;
            if (halt_wr) state_nxt = HALT;
          end
        end
      end
      CSR2: begin
        bus_wr_csr = 1'b1;
        bus_wcsrno = wcsrno_q;
        bus_val    = csrval_q;
        retire     = 1'b1;
        state_nxt  = halt_wr ? HALT : RUN;
      end
      HALT: wb_stall = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  // WB latch: takes the MEM instruction unless stalled or halted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q      <= 1'b0;
      pc_q     <= '0;
      wr_reg_q <= 1'b0;
      wregno_q <= '0;
      regval_q <= '0;
      wr_csr_q <= 1'b0;
      wcsrno_q <= '0;
      csrval_q <= '0;
    end else if (!wb_stall && state != HALT) begin
      v_q      <= mem_valid;
      pc_q     <= mem_pc;
      wr_reg_q <= mem_wr_reg;
      wregno_q <= mem_wregno;
      regval_q <= mem_regval;
      wr_csr_q <= mem_wr_csr;
      wcsrno_q <= mem_wcsrno;
      csrval_q <= mem_csrval;
    end
  end

  // State, retirement counter and halt flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= RUN;
      retired_count <= '0;
      halted        <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == HALT);
      if (retire) retired_count <= retired_count + DBITS'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a random stream
// checked against a per-cycle expected write-bus queue.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_wr_reg;
  logic [4:0]  mem_wregno;
  logic [31:0] mem_regval;
  logic        mem_wr_csr;
  logic [3:0]  mem_wcsrno;
  logic [31:0] mem_csrval;
  logic        wb_stall;
  logic [42:0] from_WB_to_DE;
  logic [31:0] retired_count;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic        wr_reg;
    logic [4:0]  wregno;
    logic [31:0] regval;
    logic        wr_csr;
    logic [3:0]  wcsrno;
    logic [31:0] csrval;
  } ins_t;

  typedef struct {
    logic [42:0] bus;
    logic        stall;
    logic        ret;
  } exp_t;

  exp_t exp_q[$];

  wb_stage dut (
    .clk(clk),
    .reset(reset),
    .mem_valid(mem_valid),
    .mem_pc(mem_pc),
    .mem_wr_reg(mem_wr_reg),
    .mem_wregno(mem_wregno),
    .mem_regval(mem_regval),
    .mem_wr_csr(mem_wr_csr),
    .mem_wcsrno(mem_wcsrno),
    .mem_csrval(mem_csrval),
    .wb_stall(wb_stall),
    .from_WB_to_DE(from_WB_to_DE),
    .retired_count(retired_count),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [42:0] mk(input logic r, input logic [4:0] n,
                                     input logic [31:0] d,
                                     input logic [3:0] c, input logic w);
    return {r, n, d, c, w};
  endfunction

  function automatic ins_t mi(input logic v, input logic r,
                              input logic [4:0] n, input logic [31:0] d,
                              input logic w, input logic [3:0] c,
                              input logic [31:0] cv);
    ins_t x;
    x.v = v; x.wr_reg = r; x.wregno = n; x.regval = d;
    x.wr_csr = w; x.wcsrno = c; x.csrval = cv;
    return x;
  endfunction

  task automatic drive(input ins_t x);
    mem_valid  = x.v;
    mem_pc     = $urandom;
    mem_wr_reg = x.wr_reg;
    mem_wregno = x.wregno;
    mem_regval = x.regval;
    mem_wr_csr = x.wr_csr;
    mem_wcsrno = x.wcsrno;
    mem_csrval = x.csrval;
  endtask

  task automatic idle();
    drive(mi(0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Model: the cycle-by-cycle bus words one accepted instruction produces.
  task automatic expand(input ins_t x);
    logic g;
    logic [42:0] gw, cw;
    g  = x.wr_reg && (x.wregno != 0);
    gw = mk(1, x.wregno, x.regval, 0, 0);
    cw = mk(0, 0, x.csrval, x.wcsrno, 1);
    if (!x.v) exp_q.push_back('{43'd0, 1'b0, 1'b0});
    else if (g && x.wr_csr) begin
      exp_q.push_back('{gw, 1'b1, 1'b0});
      exp_q.push_back('{cw, 1'b0, 1'b1});
    end else if (g) exp_q.push_back('{gw, 1'b0, 1'b1});
    else if (x.wr_csr) exp_q.push_back('{cw, 1'b0, 1'b1});
    else exp_q.push_back('{43'd0, 1'b0, 1'b1});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(mi(1, 1, 9, 32'h99, 1, 4'hF, 32'h1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (from_WB_to_DE !== 43'd0) begin
        errors++;
        $display("FAIL reset_bus i=%0d got %h exp 0", i, from_WB_to_DE);
      end
      checks++;
      if (wb_stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall i=%0d got %b exp 0", i, wb_stall);
      end
      checks++;
      if (retired_count !== 32'd0) begin
        errors++;
        $display("FAIL reset_count i=%0d got %h exp 0", i, retired_count);
      end
      checks++;
      if (halted !== 1'b0) begin
        errors++;
        $display("FAIL reset_halted i=%0d got %b exp 0", i, halted);
      end
    end
    reset = 1'b1;
    drive(mi(1, 1, 9, 32'h99, 0, 0, 0));
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== mk(1, 9, 32'h99, 0, 0)) begin
      errors++;
      $display("FAIL reset_first got %h exp %h", from_WB_to_DE,
               mk(1, 9, 32'h99, 0, 0));
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (retired_count !== 32'd1) begin
      errors++;
      $display("FAIL reset_first_count got %h exp 1", retired_count);
    end
  endtask

  task automatic test_stream();
    ins_t s[3];
    for (int i = 0; i < 3; i++)
      s[i] = mi(1, 1, 5'(5 + i), 32'(32'h11 * (i + 1)), 0, 0, 0);
    do_reset();
    drive(s[0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 2) drive(s[i + 1]);
      else idle();
      @(negedge clk);
      checks++;
      if (from_WB_to_DE !== mk(1, s[i].wregno, s[i].regval, 0, 0)) begin
        errors++;
        $display("FAIL stream_bus i=%0d got %h exp %h", i, from_WB_to_DE,
                 mk(1, s[i].wregno, s[i].regval, 0, 0));
      end
      checks++;
      if (wb_stall !== 1'b0) begin
        errors++;
        $display("FAIL stream_stall i=%0d got %b exp 0", i, wb_stall);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (retired_count !== 32'd3) begin
      errors++;
      $display("FAIL stream_count got %h exp 3", retired_count);
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(mi(1, 1, 0, 32'hDEAD, 0, 0, 0));
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== 43'd0) begin
      errors++;
      $display("FAIL x0_bus got %h exp 0", from_WB_to_DE);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (retired_count !== 32'd1) begin
      errors++;
      $display("FAIL x0_count got %h exp 1", retired_count);
    end
  endtask

  task automatic test_dual();
    do_reset();
    drive(mi(1, 1, 3, 32'h5, 1, 2, 32'hA5));
    @(posedge clk);
    #1 drive(mi(1, 1, 8, 32'h77, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== mk(1, 3, 32'h5, 0, 0) || wb_stall !== 1'b1) begin
      errors++;
      $display("FAIL dual_c1 got %h/%b exp %h/1", from_WB_to_DE, wb_stall,
               mk(1, 3, 32'h5, 0, 0));
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== mk(0, 0, 32'hA5, 2, 1) || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL dual_c2 got %h/%b exp %h/0", from_WB_to_DE, wb_stall,
               mk(0, 0, 32'hA5, 2, 1));
    end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== mk(1, 8, 32'h77, 0, 0)) begin
      errors++;
      $display("FAIL dual_held got %h exp %h", from_WB_to_DE,
               mk(1, 8, 32'h77, 0, 0));
    end
    checks++;
    if (retired_count !== 32'd1) begin
      errors++;
      $display("FAIL dual_count got %h exp 1", retired_count);
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(mi(1, 0, 0, 0, 1, 4'hF, 32'h1));
    @(posedge clk);
    #1 drive(mi(1, 1, 4, 32'h44, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== mk(0, 0, 32'h1, 4'hF, 1) || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_write got %h/%b exp %h/0", from_WB_to_DE, halted,
               mk(0, 0, 32'h1, 4'hF, 1));
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || wb_stall !== 1'b1) begin
        errors++;
        $display("FAIL halt_state i=%0d got h=%b s=%b exp 1/1", i, halted,
                 wb_stall);
      end
      checks++;
      if (from_WB_to_DE !== 43'd0 || retired_count !== 32'd1) begin
        errors++;
        $display("FAIL halt_frozen i=%0d got %h/%h exp 0/1", i,
                 from_WB_to_DE, retired_count);
      end
    end
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || wb_stall !== 1'b0 || retired_count !== 32'd0) begin
      errors++;
      $display("FAIL halt_reset got h=%b s=%b c=%h exp 0/0/0", halted,
               wb_stall, retired_count);
    end
    drive(mi(1, 0, 0, 0, 1, 4'hF, 32'h0));
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== mk(0, 0, 0, 4'hF, 1)) begin
      errors++;
      $display("FAIL nohalt_bus got %h exp %h", from_WB_to_DE,
               mk(0, 0, 0, 4'hF, 1));
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || wb_stall !== 1'b0 || retired_count !== 32'd1) begin
      errors++;
      $display("FAIL nohalt_state got h=%b s=%b c=%h exp 0/0/1", halted,
               wb_stall, retired_count);
    end
  endtask

  task automatic test_wrap_reset_csr2();
    do_reset();
    force dut.retired_count = 32'hFFFF_FFFE;
    #1 release dut.retired_count;
    drive(mi(1, 1, 1, 32'h1, 0, 0, 0));
    @(posedge clk);
    #1 drive(mi(1, 1, 2, 32'h2, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (retired_count !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL wrap_preset got %h exp fffffffe", retired_count);
    end
    @(posedge clk);
    #1 drive(mi(1, 1, 3, 32'h5, 1, 2, 32'hA5));
    @(negedge clk);
    checks++;
    if (retired_count !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_max got %h exp ffffffff", retired_count);
    end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (retired_count !== 32'd0 || wb_stall !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero got %h/%b exp 0/1", retired_count, wb_stall);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== mk(0, 0, 32'hA5, 2, 1)) begin
      errors++;
      $display("FAIL csr2_bus got %h exp %h", from_WB_to_DE,
               mk(0, 0, 32'hA5, 2, 1));
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== 43'd0 || wb_stall !== 1'b0 ||
        retired_count !== 32'd0) begin
      errors++;
      $display("FAIL csr2_reset got %h/%b/%h exp 0/0/0", from_WB_to_DE,
               wb_stall, retired_count);
    end
    drive(mi(1, 1, 3, 32'h3, 0, 0, 0));
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (from_WB_to_DE !== mk(1, 3, 32'h3, 0, 0) || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL csr2_run got %h/%b exp %h/0", from_WB_to_DE, wb_stall,
               mk(1, 3, 32'h3, 0, 0));
    end
  endtask

  task automatic test_random();
    ins_t  cur;
    exp_t  e;
    logic [31:0] mcnt;
    do_reset();
    exp_q.delete();
    exp_q.push_back('{43'd0, 1'b0, 1'b0});
    mcnt = 0;
    cur = mi($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 31)),
             $urandom, 1'($urandom), 4'($urandom_range(0, 14)), $urandom);
    drive(cur);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rand_model i=%0d got empty queue exp entry", i);
        break;
      end
      e = exp_q.pop_front();
      if (from_WB_to_DE !== e.bus || wb_stall !== e.stall ||
          retired_count !== mcnt) begin
        errors++;
        $display("FAIL rand i=%0d got %h/%b/%h exp %h/%b/%h", i,
                 from_WB_to_DE, wb_stall, retired_count, e.bus, e.stall, mcnt);
      end
      if (e.ret) mcnt++;
      if (!e.stall) expand(cur);
      @(posedge clk);
      #1;
      if (!e.stall) begin
        cur = mi($urandom_range(0, 3) != 0, 1'($urandom),
                 5'($urandom_range(0, 31)), $urandom, 1'($urandom),
                 4'($urandom_range(0, 14)), $urandom);
        drive(cur);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_stream();
    test_x0();
    test_dual();
    test_halt();
    test_wrap_reset_csr2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
